// File: rtl/run_control.sv
// Run controller: holds the CPUs in reset, releases them for a bounded or
// unbounded run, and records which channels halted and how many cycles ran.
module run_control #(
    parameter int unsigned NCHAN        = 1,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RESET_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] limit,
    input  logic [NCHAN-1:0] halt,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [NCHAN-1:0] halted,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned    HOLD_W    = 16;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        DONE,
        TIMEOUT
    } state_t;

    state_t            state, state_d;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
    logic [CNT_W-1:0]  limit_q, limit_d;
    logic [CNT_W-1:0]  cycles_d, cycles_inc;
    logic [NCHAN-1:0]  halted_d, halt_acc;
    logic              cpu_reset_d, running_d, done_d, timeout_d;
    logic              all_halted, limit_hit;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d     = state;
        hold_cnt_d  = hold_cnt;
        limit_d     = limit_q;
        halted_d    = halted;
        cycles_d    = cycles;
        cpu_reset_d = cpu_reset;
        running_d   = running;
        done_d      = done;
        timeout_d   = timeout;

        halt_acc   = halted | halt;
        all_halted = &halt_acc;
        // Timeout fires on the last allowed RUN clock, so running lasts exactly limit cycles.
        limit_hit  = (limit_q != '0) && (cycles == (limit_q - CNT_W'(1)));
        cycles_inc = (cycles == CNT_MAX) ? cycles : (cycles + CNT_W'(1));

        case (state)
            IDLE, DONE, TIMEOUT: begin
                if (start) begin
                    state_d     = HOLD;
                    hold_cnt_d  = '0;
                    limit_d     = limit;
                    halted_d    = '0;
                    cycles_d    = '0;
                    cpu_reset_d = 1'b1;
                    running_d   = 1'b0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_d     = RUN;
                    hold_cnt_d  = '0;
                    cpu_reset_d = 1'b0;
                    running_d   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                halted_d = halt_acc;
                cycles_d = cycles_inc;
                // All-halted takes precedence over a simultaneous limit hit.
                if (all_halted) begin
                    state_d   = DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                end else if (limit_hit) begin
                    state_d   = TIMEOUT;
                    running_d = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cpu_reset_d = 1'b1;
                running_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            limit_q   <= '0;
            halted    <= '0;
            cycles    <= '0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            hold_cnt  <= hold_cnt_d;
            limit_q   <= limit_d;
            halted    <= halted_d;
            cycles    <= cycles_d;
            cpu_reset <= cpu_reset_d;
            running   <= running_d;
            done      <= done_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_run_control.sv
// Bench for run_control: directed runs checked against a phase/count model
// every cycle, plus hand-computed literal expectations.
module tb_run_control;

    localparam int unsigned NCHAN = 4;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned RC    = 10;
    localparam longint      MAXC  = (longint'(1) << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [CNT_W-1:0] limit;
    logic [NCHAN-1:0] halt;
    logic             cpu_reset, running, done, timeout;
    logic [NCHAN-1:0] halted;
    logic [CNT_W-1:0] cycles;

    int total = 0;
    int bad   = 0;

    run_control #(.NCHAN(NCHAN), .CNT_W(CNT_W), .RESET_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .start(start), .limit(limit), .halt(halt),
        .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
        .halted(halted), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // Model: phase of the run, remaining hold clocks, RUN cycle count, halt mask.
    typedef enum {M_IDLE, M_HOLD, M_RUN, M_DONE, M_TO} mph_t;
    mph_t             ph = M_IDLE;
    int               hold_left = 0;
    longint           m_cyc = 0;
    longint           m_lim = 0;
    logic [NCHAN-1:0] m_halted = '0;
    bit               m_valid = 1'b0;

    always @(posedge clk) begin
        logic [NCHAN-1:0] acc;
        if (reset) begin
            ph = M_IDLE; hold_left = 0; m_cyc = 0; m_lim = 0; m_halted = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (ph)
                M_HOLD: begin
                    hold_left = hold_left - 1;
                    if (hold_left == 0) ph = M_RUN;
                end
                M_RUN: begin
                    acc = m_halted | halt;
                    if (&acc) ph = M_DONE;
                    else if (m_lim != 0 && m_cyc + 1 == m_lim) ph = M_TO;
                    m_halted = acc;
                    if (m_cyc < MAXC) m_cyc = m_cyc + 1;
                end
                default: begin
                    if (start) begin
                        ph = M_HOLD; hold_left = RC; m_lim = longint'(limit);
                        m_cyc = 0; m_halted = '0;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic e_cr, e_run, e_done, e_to;
        if (m_valid) begin
            e_cr   = (ph == M_IDLE) || (ph == M_HOLD);
            e_run  = (ph == M_RUN);
            e_done = (ph == M_DONE);
            e_to   = (ph == M_TO);
            total++;
            if (cpu_reset !== e_cr || running !== e_run || done !== e_done ||
                timeout !== e_to || halted !== m_halted || cycles !== CNT_W'(m_cyc)) begin
                bad++;
                $display("FAIL cycle_compare t=%0t got cr=%b run=%b done=%b to=%b halted=%b cycles=%0d expected cr=%b run=%b done=%b to=%b halted=%b cycles=%0d",
                         $time, cpu_reset, running, done, timeout, halted, cycles,
                         e_cr, e_run, e_done, e_to, m_halted, m_cyc);
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit s, input int l, input int h);
        start = s;
        limit = CNT_W'(l);
        halt  = NCHAN'(h);
        @(posedge clk);
        #1;
        start = 1'b0;
        halt  = '0;
    endtask

    // Advance idle clocks until the model reports RUN with the given cycle count.
    task automatic run_to(input longint k);
        int n = 0;
        while ((ph != M_RUN || m_cyc != k) && n < 2000) begin
            cyc(1'b0, 0, 0);
            n++;
        end
        if (n >= 2000) chk("run_to_bound", n, -1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_reset"}, longint'(cpu_reset), 1);
        chk({tag, "_running"}, longint'(running), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_timeout"}, longint'(timeout), 0);
        chk({tag, "_halted"}, longint'(halted), 0);
        chk({tag, "_cycles"}, longint'(cycles), 0);
    endtask

    // Count clocks spent with cpu_reset high before running rises.
    task automatic count_hold(output int n);
        int b = 0;
        n = 0;
        while (running !== 1'b1 && b < 50) begin
            if (cpu_reset === 1'b1) n++;
            cyc(1'b0, 0, 0);
            b++;
        end
    endtask

    initial begin
        int n;
        int          tc[4] = '{3, 7, 9, 15};
        int          th[4] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
        int          tm[4] = '{4'b0100, 4'b0101, 4'b1101, 4'b1111};

        reset = 1'b1; start = 1'b0; limit = '0; halt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;
        cyc(1'b0, 0, 0);
        chk("idle_no_start_running", longint'(running), 0);

        // Halt of all channels on RUN cycle 5 with limit 100.
        cyc(1'b1, 100, 0);
        count_hold(n);
        chk("hold_len_a", n, 10);
        chk("first_run_cycles", longint'(cycles), 0);
        repeat (5) cyc(1'b0, 0, 0);
        cyc(1'b0, 0, 4'hF);
        chk("a_done", longint'(done), 1);
        chk("a_cycles", longint'(cycles), 6);
        chk("a_model_cycles", m_cyc, 6);
        chk("a_timeout", longint'(timeout), 0);
        chk("a_cpu_reset", longint'(cpu_reset), 0);
        repeat (3) cyc(1'b0, 0, 4'hF);
        chk("a_cycles_hold", longint'(cycles), 6);

        // Limit 20, no halts; start and halt during HOLD/RUN must be ignored.
        cyc(1'b1, 20, 0);
        chk("b_done_cleared", longint'(done), 0);
        repeat (10) cyc(1'b1, 3, 4'hF);
        chk("b_running", longint'(running), 1);
        chk("b_halted_after_hold", longint'(halted), 0);
        n = 0;
        while (running === 1'b1 && n < 100) begin
            n++;
            cyc(n == 3, 5, 0);
        end
        chk("b_run_len", n, 20);
        chk("b_timeout", longint'(timeout), 1);
        chk("b_done", longint'(done), 0);
        chk("b_cycles", longint'(cycles), 20);
        chk("b_halted", longint'(halted), 0);

        // Four channels halting one at a time.
        cyc(1'b1, 50, 0);
        for (int k = 0; k < 4; k++) begin
            run_to(longint'(tc[k]));
            cyc(1'b0, 0, th[k]);
            chk($sformatf("c_mask_%0d", k), longint'(halted), longint'(tm[k]));
            chk($sformatf("c_done_%0d", k), longint'(done), (k == 3) ? 1 : 0);
        end
        chk("c_cycles", longint'(cycles), 16);
        chk("c_timeout", longint'(timeout), 0);

        // Last halt on the 8th RUN cycle, the same edge as limit 8.
        cyc(1'b1, 8, 0);
        run_to(2);
        cyc(1'b0, 0, 4'b0111);
        run_to(7);
        cyc(1'b0, 0, 4'b1000);
        chk("d_done", longint'(done), 1);
        chk("d_timeout", longint'(timeout), 0);
        chk("d_cycles", longint'(cycles), 8);

        // Reset mid-RUN with start and halt also high.
        cyc(1'b1, 100, 0);
        run_to(4);
        reset = 1'b1;
        cyc(1'b1, 5, 4'hF);
        reset = 1'b0;
        chk_reset_vals("e_run");
        cyc(1'b0, 0, 0);
        chk("e_stays_idle", longint'(cpu_reset), 1);

        // Reset mid-HOLD; the next run must get a full hold.
        cyc(1'b1, 100, 0);
        repeat (3) cyc(1'b0, 0, 0);
        reset = 1'b1;
        cyc(1'b1, 100, 0);
        reset = 1'b0;
        chk_reset_vals("e_hold");
        cyc(1'b0, 0, 0);
        cyc(1'b1, 0, 0);
        count_hold(n);
        chk("hold_len_e", n, 10);
        cyc(1'b0, 0, 4'hF);
        chk("e_done", longint'(done), 1);
        chk("e_cycles", longint'(cycles), 1);

        // Unlimited run from DONE: counts past 1000, then saturates.
        cyc(1'b1, 0, 0);
        run_to(1000);
        chk("f_cycles_1000", longint'(cycles), 1000);
        chk("f_running", longint'(running), 1);
        chk("f_timeout", longint'(timeout), 0);
        run_to(MAXC);
        repeat (50) cyc(1'b0, 0, 0);
        chk("f_saturated", longint'(cycles), 1023);
        chk("f_still_running", longint'(running), 1);
        chk("f_no_timeout", longint'(timeout), 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 Parameter NCHAN, default 1: number of CPU channels monitored for halt.
REQ-002 Parameter CNT_W, default 32: width of the cycle limit and cycle counter.
REQ-003 Parameter RESET_CYCLES, default 10: length of the CPU reset pulse in clocks; legal range 1..2^16-1.
REQ-004 clk  input  1: single clock; all state changes on rising edge.
REQ-005 reset  input  1: synchronous, active-high block reset.
REQ-006 start  input  1: one-cycle request to begin a run.
REQ-007 limit  input  CNT_W: run cycle limit, sampled only when start is accepted; 0 = unlimited.
REQ-008 halt  input  NCHAN: per-channel halt indication from the CPUs.
REQ-009 cpu_reset  output  1: reset driven to the CPUs.
REQ-010 running  output  1: high while CPUs execute.
REQ-011 done  output  1: sticky; all channels halted.
REQ-012 timeout  output  1: sticky; limit reached before all channels halted.
REQ-013 halted  output  NCHAN: sticky mask of channels that have halted in the current run.
REQ-014 cycles  output  CNT_W: RUN cycles elapsed in the current run.

Function
REQ-015 FSM states SHALL be IDLE, HOLD, RUN, DONE, TIMEOUT; all outputs registered.
REQ-016 IDLE: cpu_reset=1, running=0; start -> HOLD, latching limit, clearing halted/cycles/done/timeout.
REQ-017 HOLD: cpu_reset=1 for exactly RESET_CYCLES clocks, then RUN; start and halt ignored.
REQ-018 RUN: cpu_reset=0, running=1; cycles increments by 1 on every RUN clock, starting from 0 at the first RUN clock.
REQ-019 RUN: on each clock, halted <= halted | halt; halt outside RUN SHALL be ignored.
REQ-020 RUN -> DONE on the edge where (halted | halt) becomes all ones; done=1 from the next cycle.
REQ-021 RUN -> TIMEOUT on the edge where cycles == limit-1 and limit != 0 and REQ-020 not met; running high for exactly limit cycles, cycles == limit in TIMEOUT.
REQ-022 Simultaneous last halt and limit hit: DONE wins, timeout stays 0.
REQ-023 limit == 0: no timeout; cycles saturates at 2^CNT_W-1, no wrap.
REQ-024 start during HOLD or RUN SHALL be ignored.
REQ-025 DONE/TIMEOUT: running=0, cpu_reset=0 (CPU state preserved for trace dump); done/timeout, halted, cycles hold.
REQ-026 start in DONE/TIMEOUT -> HOLD, same effects as REQ-016.
REQ-027 Exactly one of done/timeout high in DONE/TIMEOUT; both 0 elsewhere.

Reset
REQ-028 reset=1 SHALL, on the next edge, force IDLE: cpu_reset=1, running=0, done=0, timeout=0, halted=0, cycles=0, HOLD counter cleared.
REQ-029 reset SHALL take priority over start and halt in the same cycle, including mid-HOLD and mid-RUN.

Verification
REQ-030 RESET_CYCLES=10, NCHAN=1, start with limit=100, halt pulse on RUN cycle 5 -> cpu_reset high 10 clocks after start, done=1, cycles=6, timeout=0.
REQ-031 limit=20, halt never asserted -> running high exactly 20 clocks, timeout=1, cycles=20, halted=0.
REQ-032 NCHAN=4, halts on channels 2,0,3,1 at RUN cycles 3,7,9,15 -> halted mask grows 0100,0101,1101,1111; done on cycle 16.
REQ-033 limit=8, last halt on RUN cycle 8 (same edge as limit) -> done=1, timeout=0.
REQ-034 reset asserted on RUN cycle 4 with start also high -> IDLE, all outputs at reset values, start ignored.
REQ-035 Second start in DONE with limit=0 and no halt for 1000 cycles -> fresh run, cycles=1000, no timeout.
